// File: rtl/mmio_timer_gpio_if.sv
// Data-side bus bundle between the core's load/store path and the peripheral.
//   WE  : store enable
//   A   : byte address (ALU result)
//   Wd  : store data
//   Rd  : read data, combinational from A
//   hit : A falls inside the peripheral window
interface mmio_timer_gpio_if;
  logic        WE;
  logic [31:0] A;
  logic [31:0] Wd;
  logic [31:0] Rd;
  logic        hit;

  modport master (output WE, A, Wd, input Rd, hit);
  modport slave  (input WE, A, Wd, output Rd, hit);
endinterface

// File: rtl/mmio_timer_gpio.sv
// Memory-mapped GPIO + prescaled 32-bit timer with compare-match interrupt.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : slave side of mmio_timer_gpio_if (WE, A, Wd in; Rd, hit out)
//   gpio_in  : asynchronous external inputs, 2-flop synchronized
//   gpio_out : registered GPIO outputs
//   irq      : interrupt, derived only from flops
// Register map (word offsets): 0x00 GPIO_OUT, 0x04 GPIO_IN, 0x08 CNT,
//   0x0C CMP, 0x10 CTRL {IE,AUTO_CLR,EN}, 0x14 STAT {PEND} (W1C).
// Optional macro MMIO_GPIO_EDGE_EN adds 0x18 EDGE (W1C) and 0x1C EDGE_IE.
module mmio_timer_gpio #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned GPIO_W    = 8,
  parameter logic [31:0] GPIO_RST  = 32'h0000_0000,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  mmio_timer_gpio_if.slave  bus,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  localparam int unsigned     PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  localparam logic [3:0] IDX_GPIO_OUT = 4'h0;
  localparam logic [3:0] IDX_GPIO_IN  = 4'h1;
  localparam logic [3:0] IDX_CNT      = 4'h2;
  localparam logic [3:0] IDX_CMP      = 4'h3;
  localparam logic [3:0] IDX_CTRL     = 4'h4;
  localparam logic [3:0] IDX_STAT     = 4'h5;
`ifdef MMIO_GPIO_EDGE_EN
  localparam logic [3:0] IDX_EDGE     = 4'h6;
  localparam logic [3:0] IDX_EDGE_IE  = 4'h7;
`endif

  logic              w_hit;
  logic              w_wr;
  logic [3:0]        w_idx;
  logic              w_stop;
  logic              w_tick;
  logic              w_match;
  logic [31:0]       w_rd;
  logic              w_unused;

  logic [GPIO_W-1:0] r_gpio_out;
  logic [GPIO_W-1:0] r_sync1;
  logic [GPIO_W-1:0] r_sync2;
  logic [31:0]       r_cnt;
  logic [31:0]       r_cmp;
  logic [2:0]        r_ctrl;
  logic              r_pend;
  logic [PRE_W-1:0]  r_pre;

  // Address decode; byte lane bits are ignored (word access only)
  assign w_hit    = (bus.A[31:6] == BASE_ADDR[31:6]);
  assign w_idx    = bus.A[5:2];
  assign w_wr     = bus.WE & w_hit;
  assign w_unused = &{1'b0, bus.A[1:0]};

  // A CTRL write clearing EN stops the timer in the same cycle it lands
  assign w_stop  = w_wr && (w_idx == IDX_CTRL) && !bus.Wd[0];
  assign w_tick  = r_ctrl[0] && !w_stop && (r_pre == PRE_LAST);
  assign w_match = w_tick && (r_cnt == r_cmp);

  // Prescaler: counts only while enabled, wraps on tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (!r_ctrl[0] || w_stop || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Timer counter: software write beats tick increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wr && (w_idx == IDX_CNT)) begin
      r_cnt <= bus.Wd;
    end else if (w_match && r_ctrl[1]) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Control/compare/GPIO registers and pending flag (set beats W1C)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gpio_out <= GPIO_RST[GPIO_W-1:0];
      r_cmp      <= 32'hFFFF_FFFF;
      r_ctrl     <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (w_wr && (w_idx == IDX_GPIO_OUT)) r_gpio_out <= bus.Wd[GPIO_W-1:0];
      if (w_wr && (w_idx == IDX_CMP))      r_cmp      <= bus.Wd;
      if (w_wr && (w_idx == IDX_CTRL))     r_ctrl     <= bus.Wd[2:0];
      if (w_match) begin
        r_pend <= 1'b1;
      end else if (w_wr && (w_idx == IDX_STAT) && bus.Wd[0]) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Two-flop input synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MMIO_GPIO_EDGE_EN
  logic [GPIO_W-1:0] r_sync3;
  logic [GPIO_W-1:0] r_edge;
  logic [GPIO_W-1:0] r_edge_ie;
  logic [GPIO_W-1:0] w_rise;
  logic [GPIO_W-1:0] w_edge_clr;

  assign w_rise     = r_sync2 & ~r_sync3;
  assign w_edge_clr = (w_wr && (w_idx == IDX_EDGE)) ? bus.Wd[GPIO_W-1:0] : '0;

  // Rising-edge capture; a new edge wins over a simultaneous W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync3   <= '0;
      r_edge    <= '0;
      r_edge_ie <= '0;
    end else begin
      r_sync3 <= r_sync2;
      r_edge  <= w_rise | (r_edge & ~w_edge_clr);
      if (w_wr && (w_idx == IDX_EDGE_IE)) r_edge_ie <= bus.Wd[GPIO_W-1:0];
    end
  end

  assign irq = (r_pend & r_ctrl[2]) | (|(r_edge & r_edge_ie));
`else
  assign irq = r_pend & r_ctrl[2];
`endif

  // Zero-latency read mux
  always_comb begin
    w_rd = '0;
    if (w_hit) begin
      case (w_idx)
        IDX_GPIO_OUT: w_rd = 32'(r_gpio_out);
        IDX_GPIO_IN:  w_rd = 32'(r_sync2);
        IDX_CNT:      w_rd = r_cnt;
        IDX_CMP:      w_rd = r_cmp;
        IDX_CTRL:     w_rd = 32'(r_ctrl);
        IDX_STAT:     w_rd = 32'(r_pend);
`ifdef MMIO_GPIO_EDGE_EN
        IDX_EDGE:     w_rd = 32'(r_edge);
        IDX_EDGE_IE:  w_rd = 32'(r_edge_ie);
`endif
        default:      w_rd = '0;
      endcase
    end
  end

  assign bus.Rd   = w_rd;
  assign bus.hit  = w_hit;
  assign gpio_out = r_gpio_out;

endmodule

// File: tb/tb_mmio_timer_gpio.sv
// Directed bench for mmio_timer_gpio with an in-bench behavioural model that
// is compared against hit/Rd/gpio_out/irq on every falling edge, plus literal
// expectations at known points. Honors MMIO_GPIO_EDGE_EN like the design.
module tb_mmio_timer_gpio;
  localparam logic [31:0] BASE     = 32'h0000_1000;
  localparam int unsigned GW       = 8;
  localparam logic [31:0] GRST     = 32'h0000_005A;
  localparam int unsigned PRESCALE = 4;

  logic          clk;
  logic          rst;
  logic [GW-1:0] gpio_in;
  logic [GW-1:0] gpio_out;
  logic          irq;
  int            n_checks;
  int            n_errors;
  bit            cmp_on;

  mmio_timer_gpio_if bus ();

  mmio_timer_gpio #(
    .BASE_ADDR(BASE), .GPIO_W(GW), .GPIO_RST(GRST), .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [GW-1:0] m_gpio_out, m_s1, m_s2, m_s3, m_edge, m_edge_ie, m_rise;
  logic [31:0]   m_cnt, m_cmp;
  logic [2:0]    m_ctrl;
  logic          m_pend;
  int unsigned   m_phase;
  bit            m_wr, m_stop, m_tick, m_match;
  logic [5:0]    m_off;

  function automatic bit in_win(input logic [31:0] a);
    return a[31:6] == BASE[31:6];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [5:0] off;
    if (!in_win(a)) return 32'h0;
    off = {a[5:2], 2'b00};
    case (off)
      6'h00: return {24'h0, m_gpio_out};
      6'h04: return {24'h0, m_s2};
      6'h08: return m_cnt;
      6'h0C: return m_cmp;
      6'h10: return {29'h0, m_ctrl};
      6'h14: return {31'h0, m_pend};
`ifdef MMIO_GPIO_EDGE_EN
      6'h18: return {24'h0, m_edge};
      6'h1C: return {24'h0, m_edge_ie};
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_irq();
`ifdef MMIO_GPIO_EDGE_EN
    return (m_pend & m_ctrl[2]) | (|(m_edge & m_edge_ie));
`else
    return m_pend & m_ctrl[2];
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_gpio_out = GRST[GW-1:0];
      m_s1 = '0; m_s2 = '0; m_s3 = '0; m_edge = '0; m_edge_ie = '0;
      m_cnt = 32'h0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 3'b0; m_pend = 1'b0;
      m_phase = 0;
    end else begin
      m_wr    = bus.WE && in_win(bus.A);
      m_off   = {bus.A[5:2], 2'b00};
      m_stop  = m_wr && (m_off == 6'h10) && !bus.Wd[0];
      m_tick  = m_ctrl[0] && !m_stop && (m_phase == PRESCALE - 1);
      m_match = m_tick && (m_cnt == m_cmp);
      m_rise  = m_s2 & ~m_s3;
      // prescaler counts enabled cycles modulo PRESCALE
      m_phase = (m_ctrl[0] && !m_stop) ? (m_phase + 1) % PRESCALE : 0;
      if (m_wr && m_off == 6'h08)  m_cnt = bus.Wd;
      else if (m_match && m_ctrl[1]) m_cnt = 32'h0;
      else if (m_tick)             m_cnt = m_cnt + 32'd1;
      if (m_wr && m_off == 6'h14 && bus.Wd[0]) m_pend = 1'b0;
      if (m_match) m_pend = 1'b1;
      if (m_wr && m_off == 6'h00) m_gpio_out = bus.Wd[GW-1:0];
      if (m_wr && m_off == 6'h0C) m_cmp = bus.Wd;
      if (m_wr && m_off == 6'h10) m_ctrl = bus.Wd[2:0];
      if (m_wr && m_off == 6'h18) m_edge = m_edge & ~bus.Wd[GW-1:0];
      m_edge = m_edge | m_rise;
      if (m_wr && m_off == 6'h1C) m_edge_ie = bus.Wd[GW-1:0];
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = gpio_in;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst && cmp_on) begin
      check("model_hit", {31'h0, bus.hit}, {31'h0, in_win(bus.A)});
      check("model_rd", bus.Rd, exp_rd(bus.A));
      check("model_gpio_out", {24'h0, gpio_out}, {24'h0, m_gpio_out});
      check("model_irq", {31'h0, irq}, {31'h0, exp_irq()});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.A = addr; bus.Wd = data; bus.WE = 1'b1;
    step();
    bus.WE = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus.A = addr; #1;
    check(name, bus.Rd, exp);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cmp_on = 1'b0;
    rst = 1'b1; gpio_in = '0;
    bus.WE = 1'b0; bus.A = 32'h0; bus.Wd = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; cmp_on = 1'b1;

    // reset values
    rd_chk("rst_gpio_out", 32'h1000, 32'h0000_005A);
    rd_chk("rst_gpio_in",  32'h1004, 32'h0);
    rd_chk("rst_cnt",      32'h1008, 32'h0);
    rd_chk("rst_cmp",      32'h100C, 32'hFFFF_FFFF);
    rd_chk("rst_ctrl",     32'h1010, 32'h0);
    rd_chk("rst_stat",     32'h1014, 32'h0);
    rd_chk("rst_unmapped", 32'h1020, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rd_chk("miss_rd", 32'h2000, 32'h0);
    check("miss_hit", {31'h0, bus.hit}, 32'h0);

    // GPIO out (upper Wd bits discarded) and synchronized input latency
    wr(32'h1000, 32'hFFFF_FFA5);
    check("gpio_out_a5", {24'h0, gpio_out}, 32'hA5);
    rd_chk("gpio_out_rd", 32'h1003, 32'hA5);
    gpio_in = 8'h3C;
    bus.A = 32'h1004;
    step(); rd_chk("gpio_in_1st_edge", 32'h1004, 32'h0);
    step(); rd_chk("gpio_in_2nd_edge", 32'h1004, 32'h3C);

    // timer match with auto-clear and interrupt
    wr(32'h100C, 32'h3);
    wr(32'h1010, 32'h7);
    repeat (15) step();
    rd_chk("pre_match_stat", 32'h1014, 32'h0);
    check("pre_match_irq", {31'h0, irq}, 32'h0);
    step();
    rd_chk("match_stat", 32'h1014, 32'h1);
    check("match_irq", {31'h0, irq}, 32'h1);
    rd_chk("match_cnt_clr", 32'h1008, 32'h0);
    wr(32'h1014, 32'h1);
    check("w1c_irq", {31'h0, irq}, 32'h0);

    // W1C colliding with a new match: set wins
    repeat (14) step();
    wr(32'h1014, 32'h1);
    rd_chk("collide_stat", 32'h1014, 32'h1);
    check("collide_irq", {31'h0, irq}, 32'h1);

    // CNT write in a tick cycle: write wins
    repeat (3) step();
    wr(32'h1008, 32'h10);
    rd_chk("cnt_wr_tick", 32'h1008, 32'h10);
    wr(32'h1014, 32'h1);

    // free-running wrap with no auto-clear
    wr(32'h1010, 32'h0);
    wr(32'h1008, 32'hFFFF_FFFE);
    wr(32'h100C, 32'h5);
    wr(32'h1010, 32'h1);
    repeat (8) step();
    rd_chk("wrap_cnt", 32'h1008, 32'h0);
    rd_chk("wrap_stat", 32'h1014, 32'h0);
    repeat (20) step();
    rd_chk("pre5_cnt", 32'h1008, 32'h5);
    repeat (4) step();
    rd_chk("run_match_stat", 32'h1014, 32'h1);
    rd_chk("run_match_cnt", 32'h1008, 32'h6);
    check("run_match_irq_off", {31'h0, irq}, 32'h0);

    // disable freezes the counter
    wr(32'h1010, 32'h0);
    repeat (10) step();
    rd_chk("frozen_cnt", 32'h1008, 32'h6);
    wr(32'h1014, 32'h1);

`ifdef MMIO_GPIO_EDGE_EN
    wr(32'h1018, 32'hFF);
    rd_chk("edge_cleared", 32'h1018, 32'h0);
    wr(32'h101C, 32'h04);
    gpio_in = 8'h38;
    repeat (4) step();
    rd_chk("edge_fall_none", 32'h1018, 32'h0);
    gpio_in = 8'h3C;
    step(); rd_chk("edge_e1", 32'h1018, 32'h0);
    step(); rd_chk("edge_e2", 32'h1018, 32'h0);
    step(); rd_chk("edge_set", 32'h1018, 32'h04);
    check("edge_irq", {31'h0, irq}, 32'h1);
    gpio_in = 8'h38;
    repeat (4) step();
    wr(32'h1018, 32'h04);
    rd_chk("edge_w1c", 32'h1018, 32'h0);
    check("edge_w1c_irq", {31'h0, irq}, 32'h0);
    gpio_in = 8'h3C;
    step(); step();
    wr(32'h1018, 32'h04);
    rd_chk("edge_set_wins", 32'h1018, 32'h04);
`else
    rd_chk("no_edge_rd", 32'h1018, 32'h0);
    wr(32'h1018, 32'hFF);
    wr(32'h101C, 32'hFF);
    rd_chk("no_edge_wr", 32'h1018, 32'h0);
    rd_chk("no_edge_ie", 32'h101C, 32'h0);
    check("no_edge_irq", {31'h0, irq}, 32'h0);
`endif

    // asynchronous reset mid-count, then first tick after PRESCALE cycles
    wr(32'h1010, 32'h1);
    repeat (10) step();
    rd_chk("pre_rst_cnt", 32'h1008, 32'h8);
    #1 rst = 1'b1;
    rd_chk("async_rst_cnt", 32'h1008, 32'h0);
    rd_chk("async_rst_ctrl", 32'h1010, 32'h0);
    check("async_rst_gpio", {24'h0, gpio_out}, 32'h5A);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wr(32'h1010, 32'h1);
    repeat (3) step();
    rd_chk("post_rst_no_tick", 32'h1008, 32'h0);
    step();
    rd_chk("post_rst_tick", 32'h1008, 32'h1);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mmio_timer_gpio.md
Name: mmio_timer_gpio

Overview:
- Memory-mapped peripheral on the processor's data-side bus, in parallel with the data memory.
- Decodes ALU address, write enable and store data for one address window.
- Provides a GPIO output register, a synchronized GPIO input port, and a prescaled 32-bit timer with compare-match interrupt.
- The top level muxes Rd into the load path when hit=1.

Parameters:
- BASE_ADDR, 32'h0000_1000, window base; window is 64 bytes (A[31:6] == BASE_ADDR[31:6]).
- GPIO_W, 8, GPIO output and input width (1..32).
- GPIO_RST, 0, reset value of gpio_out.
- PRESCALE, 4, clock cycles per timer tick (>=1); PRESCALE=1 ticks every cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- WE  input  1  store enable from control unit.
- A  input  32  byte address (ALU result).
- Wd  input  32  store data.
- Rd  output  32  read data, combinational from A.
- hit  output  1  A falls in window; combinational.
- gpio_in  input  GPIO_W  asynchronous external inputs.
- gpio_out  output  GPIO_W  registered outputs.
- irq  output  1  timer interrupt, registered-state derived.

Behaviour:
- Register map (offset = A[5:2]<<2; A[1:0] ignored, word access only):
  - 0x00 GPIO_OUT rw.
  - 0x04 GPIO_IN ro: 2-flop synchronized value.
  - 0x08 CNT rw.
  - 0x0C CMP rw.
  - 0x10 CTRL rw: bit0 EN, bit1 AUTO_CLR, bit2 IE.
  - 0x14 STAT: bit0 PEND, write-1-to-clear.
  - Other offsets read 0; writes to them are ignored.
- Reads are combinational, with zero latency, so a single-cycle load completes in the same cycle. Rd=0 when hit=0. Unused upper bits read 0.
- Writes take effect at the rising clk edge when WE & hit. Wd bits beyond a register's width are discarded.
- Reset values:
  - gpio_out=GPIO_RST.
  - CNT=0, CMP=32'hFFFF_FFFF, CTRL=0, PEND=0.
  - Synchronizer flops=0, prescaler=0, irq=0.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN=1.
  - tick=1 in the cycle it equals PRESCALE-1; it then wraps to 0.
  - Held at 0 while EN=0.
- Timer on tick:
  - Match when CNT==CMP.
  - On match: PEND<=1, and CNT<=0 if AUTO_CLR, else CNT<=CNT+1.
  - On no match: CNT<=CNT+1.
  - 32-bit wrap FFFF_FFFF -> 0 is silent unless that value equals CMP.
- Collisions:
  - Software write to CNT in a tick cycle: write wins, no increment that cycle. Match evaluation still uses the pre-write CNT.
  - Writing CTRL.EN=0 freezes CNT immediately and resets the prescaler.
  - W1C of PEND in the same cycle as a new match: set wins, PEND=1.
- irq = PEND & IE, a pure function of flops; changes one cycle after the causing edge.
- GPIO_IN latency: an external change is visible in Rd after two rising edges.
- Asynchronous reset mid-count returns all state to reset values immediately. The first tick after reset release requires PRESCALE cycles with EN=1.

Optional Feature:
- Macro: MMIO_GPIO_EDGE_EN.
- When defined:
  - Adds offset 0x18 EDGE (GPIO_W bits, W1C). Bit i sets on a synchronized rising edge of gpio_in[i] (sync2 & ~sync3, one extra flop stage).
  - Adds offset 0x1C EDGE_IE.
  - irq = (PEND & IE) | |(EDGE & EDGE_IE).
  - Set wins over a simultaneous W1C.
- When undefined: 0x18 and 0x1C read 0, writes are ignored, no extra flops, irq = PEND & IE.

Test Plan:
- Reset: after reset, read each offset -> GPIO_OUT=GPIO_RST, CNT=0, CMP=FFFF_FFFF, CTRL=0, STAT=0, irq=0. A=0x0000_2000 -> hit=0, Rd=0.
- GPIO: write 0xA5 to 0x1000 -> gpio_out=0xA5 after the edge. Drive gpio_in=0x3C -> read of 0x1004 shows 0x3C on the 2nd edge, not the 1st.
- Timer match: PRESCALE=4, CMP=3, CTRL=0b111 -> PEND=1 and irq=1 one cycle after the 4th tick (cycle 16 after the enable write). CNT reads 0 afterward. Write 1 to 0x1014 -> irq=0.
- Collision: W1C of STAT in the exact match cycle -> PEND remains 1. CNT write 0x10 in a tick cycle -> CNT reads 0x10, not 0x11.
- Free-run wrap: AUTO_CLR=0, CNT=FFFF_FFFE, CMP=5 -> two ticks give CNT=0 with PEND=0. Match at CNT=5 sets PEND, and CNT continues to 6.
- Edge (macro on): gpio_in[2] 0->1 -> EDGE=0x04, irq=1 if EDGE_IE[2]=1. Simultaneous W1C and a new edge -> bit stays set.
